// File: rtl/if_id_register.sv
// ----------------------------------------------------------------------------
// if_id_register
//
// Fetch-to-decode pipeline register for the MIPS datapath. Captures the
// fetched instruction word and PC+4 once per clock, with flush (bubble
// insertion) taking priority over stall (hold), which takes priority over a
// normal load. Decoded instruction fields are pure slices of the registered
// word, so they arrive with no latency beyond the register itself.
//
// Parameters:
//   NOP_WORD     instruction word loaded on reset, flush and bubbles
//   COUNT_WIDTH  width of the saturating stall/flush event counters
//
// Ports:
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   in_pc_plus4      PC+4 from the fetch stage
//   in_instruction   instruction word from instruction memory
//   in_valid         fetch stage holds a real instruction this cycle
//   stall            hazard unit request: hold current contents
//   flush            branch/jump resolution: insert a bubble
//   out_pc_plus4     registered PC+4
//   out_instruction  registered instruction word
//   out_valid        registered word is a real instruction, not a bubble
//   out_opcode .. out_jaddr  field slices of out_instruction
//   stall_count      cycles in which a stall took effect (saturating)
//   flush_count      cycles in which a flush took effect (saturating)
// ----------------------------------------------------------------------------
module if_id_register #(
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [31:0]            in_pc_plus4,
  input  logic [31:0]            in_instruction,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  output logic [31:0]            out_pc_plus4,
  output logic [31:0]            out_instruction,
  output logic                   out_valid,
  output logic [5:0]             out_opcode,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shamt,
  output logic [5:0]             out_funct,
  output logic [15:0]            out_imm16,
  output logic [25:0]            out_jaddr,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]            r_instruction;
  logic [31:0]            r_pc_plus4;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_stall_count;
  logic [COUNT_WIDTH-1:0] r_flush_count;

  // A stall only counts as taking effect when no flush overrides it.
  logic w_stall_taken;
  logic w_load;
  logic w_stall_sat;
  logic w_flush_sat;

  assign w_stall_taken = stall & ~flush;
  assign w_load        = ~stall & ~flush;
  assign w_stall_sat   = &r_stall_count;
  assign w_flush_sat   = &r_flush_count;

  // Pipeline contents. Flush leaves the PC untouched: only the instruction
  // is squashed. A bubble loaded with in_valid=0 still tracks the PC so that
  // downstream PC-relative logic sees a sensible value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instruction <= NOP_WORD;
      r_pc_plus4    <= 32'h0000_0000;
      r_valid       <= 1'b0;
    end else if (flush) begin
      r_instruction <= NOP_WORD;
      r_valid       <= 1'b0;
    end else if (w_load) begin
      r_pc_plus4 <= in_pc_plus4;
      if (in_valid) begin
        r_instruction <= in_instruction;
        r_valid       <= 1'b1;
      end else begin
        r_instruction <= NOP_WORD;
        r_valid       <= 1'b0;
      end
    end
  end

  // Saturating event counters for hazard-unit debug.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_taken && !w_stall_sat) begin
        r_stall_count <= r_stall_count + CountOne;
      end
      if (flush && !w_flush_sat) begin
        r_flush_count <= r_flush_count + CountOne;
      end
    end
  end

  assign out_instruction = r_instruction;
  assign out_pc_plus4    = r_pc_plus4;
  assign out_valid       = r_valid;
  assign stall_count     = r_stall_count;
  assign flush_count     = r_flush_count;

  assign out_opcode = r_instruction[31:26];
  assign out_rs     = r_instruction[25:21];
  assign out_rt     = r_instruction[20:16];
  assign out_rd     = r_instruction[15:11];
  assign out_shamt  = r_instruction[10:6];
  assign out_funct  = r_instruction[5:0];
  assign out_imm16  = r_instruction[15:0];
  assign out_jaddr  = r_instruction[25:0];

endmodule

// File: tb/tb_if_id_register.sv
module tb_if_id_register;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_instruction;
  logic        in_valid;
  logic        stall;
  logic        flush;

  logic [31:0] out_pc_plus4, out_instruction;
  logic        out_valid;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic [25:0] out_jaddr;
  logic [15:0] stall_count, flush_count;

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  logic [31:0] s_pc_plus4, s_instruction;
  logic        s_valid;
  logic [5:0]  s_opcode, s_funct;
  logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
  logic [15:0] s_imm16;
  logic [25:0] s_jaddr;
  logic [3:0]  s_stall_count, s_flush_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_instr, m_pc;
  logic        m_valid;
  int          m_stall, m_flush, m_stall4, m_flush4;

  if_id_register dut (
    .clock(clock), .reset_n(reset_n), .in_pc_plus4(in_pc_plus4),
    .in_instruction(in_instruction), .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_pc_plus4(out_pc_plus4), .out_instruction(out_instruction), .out_valid(out_valid),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_jaddr(out_jaddr), .stall_count(stall_count), .flush_count(flush_count)
  );

  if_id_register #(.COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_pc_plus4(in_pc_plus4),
    .in_instruction(in_instruction), .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_pc_plus4(s_pc_plus4), .out_instruction(s_instruction), .out_valid(s_valid),
    .out_opcode(s_opcode), .out_rs(s_rs), .out_rt(s_rt), .out_rd(s_rd),
    .out_shamt(s_shamt), .out_funct(s_funct), .out_imm16(s_imm16),
    .out_jaddr(s_jaddr), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr  = 32'h0;
    m_pc     = 32'h0;
    m_valid  = 1'b0;
    m_stall  = 0;
    m_flush  = 0;
    m_stall4 = 0;
    m_flush4 = 0;
  endtask

  // Behaviour of one rising edge: flush > stall > load, counters saturate.
  task automatic model_edge();
    if (flush) begin
      m_instr  = 32'h0;
      m_valid  = 1'b0;
      m_flush  = (m_flush  < 65535) ? m_flush  + 1 : m_flush;
      m_flush4 = (m_flush4 < 15)    ? m_flush4 + 1 : m_flush4;
    end else if (stall) begin
      m_stall  = (m_stall  < 65535) ? m_stall  + 1 : m_stall;
      m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : m_stall4;
    end else begin
      m_pc    = in_pc_plus4;
      m_instr = in_valid ? in_instruction : 32'h0;
      m_valid = in_valid;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".instr"},  out_instruction, m_instr);
    check({tag, ".pc"},     out_pc_plus4, m_pc);
    check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, ".opcode"}, {26'd0, out_opcode}, {26'd0, m_instr[31:26]});
    check({tag, ".rs"},     {27'd0, out_rs}, {27'd0, m_instr[25:21]});
    check({tag, ".rt"},     {27'd0, out_rt}, {27'd0, m_instr[20:16]});
    check({tag, ".rd"},     {27'd0, out_rd}, {27'd0, m_instr[15:11]});
    check({tag, ".shamt"},  {27'd0, out_shamt}, {27'd0, m_instr[10:6]});
    check({tag, ".funct"},  {26'd0, out_funct}, {26'd0, m_instr[5:0]});
    check({tag, ".imm16"},  {16'd0, out_imm16}, {16'd0, m_instr[15:0]});
    check({tag, ".jaddr"},  {6'd0, out_jaddr}, {6'd0, m_instr[25:0]});
    check({tag, ".scnt"},   {16'd0, stall_count}, m_stall);
    check({tag, ".fcnt"},   {16'd0, flush_count}, m_flush);
    check({tag, ".scnt4"},  {28'd0, s_stall_count}, m_stall4);
    check({tag, ".fcnt4"},  {28'd0, s_flush_count}, m_flush4);
    check({tag, ".instr4"}, s_instruction, m_instr);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v,
                       input logic st, input logic fl);
    in_instruction = instr;
    in_pc_plus4    = pc;
    in_valid       = v;
    stall          = st;
    flush          = fl;
  endtask

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all("reset_async");
    repeat (2) @(posedge clock);
    #1 compare_all("reset_hold");
    reset_n = 1'b1;

    // First capture after release
    drive(32'h2108FFFF, 32'h4, 1'b1, 1'b0, 1'b0);
    step("load_addi");
    check("addi.opcode", {26'd0, out_opcode}, 32'h08);
    check("addi.rs", {27'd0, out_rs}, 32'd8);
    check("addi.imm16", {16'd0, out_imm16}, 32'hFFFF);

    // Load then stall three edges while inputs change
    drive(32'h012A4020, 32'h8, 1'b1, 1'b0, 1'b0);
    step("load_add");
    drive(32'hDEADBEEF, 32'hC, 1'b1, 1'b1, 1'b0);
    repeat (3) step("stall");
    check("stall.instr", out_instruction, 32'h012A4020);
    check("stall.rd", {27'd0, out_rd}, 32'd8);
    check("stall.funct", {26'd0, out_funct}, 32'h20);
    check("stall.count", {16'd0, stall_count}, 32'd3);

    // Flush overrides stall
    drive(32'hDEADBEEF, 32'hC, 1'b1, 1'b1, 1'b1);
    step("flush_over_stall");
    check("fos.fcnt", {16'd0, flush_count}, 32'd1);
    check("fos.scnt", {16'd0, stall_count}, 32'd3);

    // Bubble load with in_valid low still takes the PC
    drive(32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, 1'b0);
    step("bubble_load");
    check("bubble.pc", out_pc_plus4, 32'h10);

    // Stalled bubble stays a bubble
    drive(32'h12345678, 32'h14, 1'b1, 1'b1, 1'b0);
    step("stalled_bubble");

    // Saturation of the narrow counter
    repeat (20) step("sat");
    check("sat.scnt4", {28'd0, s_stall_count}, 32'hF);

    // Glitch on flush between edges must not matter
    drive(32'hCAFE0001, 32'h20, 1'b1, 1'b0, 1'b0);
    #2 flush = 1'b1;
    #1 flush = 1'b0;
    step("glitch");

    // Asynchronous reset mid-cycle while holding a valid instruction
    drive(32'h8C880004, 32'h24, 1'b1, 1'b0, 1'b0);
    step("pre_reset");
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(posedge clock);
    #1 compare_all("async_reset_held");
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom, $urandom, ($urandom_range(0, 99) < 80),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- Fetch-to-decode pipeline register for the MIPS datapath.
- Captures the fetched instruction word and PC+4, and supports stall (hold) and flush (bubble insertion).
- Presents decoded instruction fields to the decode stage. out_imm16 drives the 16-bit immediate input of the sign-extension unit directly; rs/rt/rd go to the register file.
- Keeps saturating stall and flush event counters for hazard-unit debug.

Parameters:
- NOP_WORD, 32'h00000000, instruction word loaded on reset and flush (sll $0,$0,0).
- COUNT_WIDTH, 16, width of the stall and flush event counters.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_pc_plus4  input  32  PC+4 from the fetch stage.
- in_instruction  input  32  instruction word from instruction memory.
- in_valid  input  1  fetch stage has a real instruction this cycle.
- stall  input  1  from hazard unit; hold current contents.
- flush  input  1  from branch/jump resolution; insert a bubble.
- out_pc_plus4  output  32  registered PC+4.
- out_instruction  output  32  registered instruction word.
- out_valid  output  1  registered instruction is real, not a bubble.
- out_opcode  output  6  out_instruction[31:26].
- out_rs  output  5  out_instruction[25:21].
- out_rt  output  5  out_instruction[20:16].
- out_rd  output  5  out_instruction[15:11].
- out_shamt  output  5  out_instruction[10:6].
- out_funct  output  6  out_instruction[5:0].
- out_imm16  output  16  out_instruction[15:0], feeds the sign-extension unit.
- out_jaddr  output  26  out_instruction[25:0].
- stall_count  output  COUNT_WIDTH  cycles in which a stall took effect.
- flush_count  output  COUNT_WIDTH  cycles in which a flush took effect.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect without waiting for a clock edge, including mid-operation):
  - out_instruction=NOP_WORD, out_pc_plus4=0, out_valid=0.
  - stall_count=0, flush_count=0.
  - Registers stay in reset while reset_n is low.
  - The first capture happens on the first rising edge after reset_n goes high.
- Field outputs are pure combinational slices of the registered out_instruction; no extra latency.
- Latency: in_* to out_* is exactly one clock edge.
- Per rising edge, priority is flush > stall > load:
  - flush=1: out_instruction<=NOP_WORD, out_valid<=0, out_pc_plus4 holds its value. stall is ignored that cycle. flush_count increments.
  - flush=0, stall=1: all of out_instruction, out_pc_plus4 and out_valid hold. stall_count increments.
  - flush=0, stall=0, in_valid=1: out_instruction<=in_instruction, out_pc_plus4<=in_pc_plus4, out_valid<=1.
  - flush=0, stall=0, in_valid=0: out_instruction<=NOP_WORD, out_valid<=0, out_pc_plus4<=in_pc_plus4.
- Counters:
  - Unsigned, saturating at all-ones; no wrap.
  - Each counter increments at most by 1 per cycle.
  - Stall counts only when not overridden by flush.
- A stalled bubble remains a bubble: out_valid stays 0 and out_instruction stays NOP_WORD.
- stall, flush and in_valid are sampled only at the clock edge; input glitches between edges have no effect.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset release, then in_instruction=32'h2108FFFF, in_pc_plus4=32'h00000004, in_valid=1 for one edge → out_instruction=32'h2108FFFF, out_opcode=6'h08, out_rs=8, out_rt=8, out_imm16=16'hFFFF, out_pc_plus4=4, out_valid=1.
- Loaded 32'h012A4020, then stall=1 for 3 edges while inputs change to 32'hDEADBEEF → outputs hold 32'h012A4020, out_rd=8, out_funct=6'h20, stall_count=3.
- stall=1 and flush=1 on the same edge → out_instruction=32'h00000000, out_valid=0, flush_count+1, stall_count unchanged.
- in_valid=0 with in_instruction=32'hFFFFFFFF, in_pc_plus4=32'h00000010 → out_instruction=0, out_valid=0, out_pc_plus4=32'h10.
- COUNT_WIDTH=4, hold stall=1 for 20 edges → stall_count stops at 4'hF with no wrap.
- Assert reset_n low between clock edges while out_valid=1 → outputs clear immediately, before the next edge; counters read 0.
